// File: rtl/sumator_secvential_16_biti.sv
// Nibble-serial adder/subtractor: one 4-bit carry-lookahead slice evaluated per clock,
// with group P/G folded into the running carry and valid/ready handshakes on both sides.
module sumator_secvential_16_biti #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = $clog2(NIBBLES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    logic [1:0]       state_r;
    logic [IDX_W-1:0] idx_r;
    logic             carry_r;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             out_valid_r;

    logic [3:0] nib_a_s;
    logic [3:0] nib_b_s;
    logic [5:0] slice_s;
    logic [3:0] slice_sum_s;
    logic       slice_p_s;
    logic       slice_g_s;
    logic       next_carry_s;

    // 4-bit carry-lookahead slice: returns {G, P, sum[3:0]}
    function automatic logic [5:0] cla_slice(input logic [3:0] x, input logic [3:0] y, input logic c);
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] c_in;
        logic       grp_p;
        logic       grp_g;
        p       = x ^ y;
        g       = x & y;
        c_in[0] = c;
        c_in[1] = g[0] | (p[0] & c);
        c_in[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        c_in[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        grp_p   = &p;
        grp_g   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {grp_g, grp_p, p ^ c_in};
    endfunction

    // Select the active nibble and evaluate the lookahead slice on it
    always_comb begin
        nib_a_s      = opa_r[idx_r*4 +: 4];
        nib_b_s      = opb_r[idx_r*4 +: 4];
        slice_s      = cla_slice(nib_a_s, nib_b_s, carry_r);
        slice_sum_s  = slice_s[3:0];
        slice_p_s    = slice_s[4];
        slice_g_s    = slice_s[5];
        next_carry_s = slice_g_s | (slice_p_s & carry_r);
    end

    // Handshake FSM, operand capture and nibble-by-nibble result assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            carry_r     <= 1'b0;
            opa_r       <= '0;
            opb_r       <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        opa_r   <= a;
                        opb_r   <= sub ? ~b : b;
                        carry_r <= sub ? 1'b1 : cin;
                        idx_r   <= '0;
                        state_r <= ADD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ADD: begin
                    sum_r[idx_r*4 +: 4] <= slice_sum_s;
                    carry_r             <= next_carry_s;
                    if (idx_r == LAST_IDX) begin
                        cout_r      <= next_carry_s;
                        // Overflow: like-signed operands producing a result of the other sign
                        ovf_r       <= (opa_r[WIDTH-1] == opb_r[WIDTH-1]) &&
                                       (slice_sum_s[3] != opa_r[WIDTH-1]);
                        out_valid_r <= 1'b1;
                        idx_r       <= '0;
                        state_r     <= DONE;
                    end else begin
                        idx_r <= idx_r + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    idx_r       <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: doc/sumator_secvential_16_biti.md
# sumator_secvential_16_biti

Nibble-serial WIDTH-bit adder/subtractor that sits directly downstream of the team's 4-bit carry-lookahead slice. The slice interface is (a, b, cin -> sum, group P, group G). This block drives one 4-bit slice per clock, combines the returned group propagate/generate into the next carry, and assembles the full-width result. It uses a valid/ready handshake on both sides, so a datapath controller can issue wide additions while the area stays at a single lookahead slice.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4, minimum 8.
- NIBBLES, WIDTH/4, derived; number of ADD cycles.

- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept; equals (state == IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  1: compute a - b (b inverted, carry-in forced to 1).
- out_valid  output  1  result registers hold a completed result.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result, registered.
- cout  output  1  carry out of the MSB; for subtract, 1 means no borrow.
- ovf  output  1  two's-complement overflow.

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE: in_ready=1. On in_valid at an edge, latch a into opa, and b (or ~b if sub) into opb. Set carry = sub ? 1 : cin, idx=0, go to ADD.
- ADD: each cycle feed nibble idx of opa/opb plus carry to a 4-bit lookahead slice.
  - Write the slice sum into sum[4*idx+3 : 4*idx].
  - carry <= G | (P & carry); idx++.
  - At idx == NIBBLES-1: set cout = G | (P & carry), set ovf = (opa[MSB] == opb[MSB]) && (new sum MSB != opa[MSB]), go to DONE.
- DONE: out_valid=1. Hold sum/cout/ovf until out_valid && out_ready at an edge, then go to IDLE.
- in_valid, a, b, cin and sub are ignored outside IDLE; no queuing.
- sum nibbles update during ADD. Contents are meaningful only while out_valid=1.
- Arithmetic is modulo 2^WIDTH; carry out of the MSB appears only on cout.
- The slice may be an instance of the team's 4-bit lookahead slice or equivalent logic. Nibble carry must come from its P/G, not from a full-width adder.

## Timing
- Reset (rst=1 at an edge) forces:
  - state=IDLE, idx=0, carry=0
  - sum=0, cout=0, ovf=0, out_valid=0
  - in_ready=1 from the following cycle
- Reset overrides all other activity, including mid-ADD and DONE. The in-flight operation is discarded and out_valid is never asserted for it.
- Latency: for an accept at edge T, out_valid=1 after edge T+NIBBLES (4 cycles for WIDTH=16).
- Result consume at edge U: out_valid=0 and in_ready=1 after U. The earliest next accept is edge U+1.
- Minimum issue interval is NIBBLES+2 cycles; there is no back-to-back overlap.
- in_ready is combinational from state only, with no path from in_valid.
- All other outputs are registered.
- out_ready held low keeps DONE indefinitely; outputs stay stable and in_ready stays 0.
- out_ready high outside DONE has no effect.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, sum=0x0000, cout=0, ovf=0, in_ready=1 after release; no operation starts during reset.
- Basic add: a=0x1234, b=0x4321, cin=0, sub=0 -> sum=0x5555, cout=0, ovf=0; out_valid rises exactly 4 cycles after the accepting edge.
- Full carry ripple through every nibble: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0. Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
- Subtract, with cin=1 applied and required to be ignored: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0. Second case: a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: out_ready=0 for 10 cycles after the result, with new in_valid/a/b toggling -> sum/cout/ovf stable, in_ready=0, nothing accepted. Then raise out_ready -> in_ready=1 next cycle, next operand accepted and correct.
- Reset mid-operation: assert rst on the 2nd ADD cycle -> out_valid never rises, state IDLE, sum=0. A following operation a=0x00FF, b=0x0001 -> sum=0x0100, cout=0.
